key_expand_ctrl: RTL and testbench

KEY_EXPAND_CTRL -- requirements
Module: key_expand_ctrl

---
 rtl/key_expand_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_key_expand_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/key_expand_ctrl.sv
// AES-128 key schedule controller: expands a cipher key into eleven round
// keys, one round per clock, and serves registered random-access reads of
// the stored schedule.

// Combinational AES-128 key-expansion round: previous round key -> next.
module gen_rnd_key (
  input  logic [3:0]   rnd,
  input  logic [127:0] key_prev,
  output logic [127:0] key_next
);

  // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    logic [7:0] bb;
    p  = 8'h00;
    aa = a;
    bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
      bb = {1'b0, bb[7:1]};
    end
    return p;
  endfunction

  // S-box computed as multiplicative inverse (x^254) plus affine transform,
  // so no 256-entry table is needed.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] b;
    r = x;
    for (int i = 0; i < 6; i++) r = gf_mul(gf_mul(r, r), x);  // x^127
    b = gf_mul(r, r);                                          // x^254
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^
           {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  // Round constant for rounds 1..10; unused round numbers give zero.
  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rot_w, tmp_w;
  logic [31:0] n0, n1, n2, n3;

  // One key-schedule step: RotWord, SubWord, Rcon, then the XOR chain.
  always_comb begin
    w0    = key_prev[127:96];
    w1    = key_prev[95:64];
    w2    = key_prev[63:32];
    w3    = key_prev[31:0];
    rot_w = {w3[23:0], w3[31:24]};
    tmp_w = {sbox(rot_w[31:24]) ^ rcon(rnd), sbox(rot_w[23:16]),
             sbox(rot_w[15:8]), sbox(rot_w[7:0])};
    n0       = w0 ^ tmp_w;
    n1       = w1 ^ n0;
    n2       = w2 ^ n1;
    n3       = w3 ^ n2;
    key_next = {n0, n1, n2, n3};
  end

endmodule

// Key schedule controller with round-key storage and read port.
module key_expand_ctrl (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         done,
  output logic         keys_valid,
  input  logic         rd_en,
  input  logic [3:0]   rd_idx,
  output logic [127:0] rd_key,
  output logic         rd_vld,
  output logic         rd_err
);

  localparam logic [3:0] LAST_RND = 4'd10;

  typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;

  state_t       state_q, state_d;
  logic [3:0]   rnd;
  logic [127:0] rk [0:10];
  logic [127:0] rk_prev;
  logic [127:0] key_gen;
  logic         start_acc;
  logic         last_rnd;
  logic         rd_ok;

  assign rk_prev = rk[4'(rnd - 4'd1)];
  assign busy    = (state_q == EXPAND);
  assign rd_ok   = keys_valid && (rd_idx <= LAST_RND);

  gen_rnd_key u_gen_rnd_key (
    .rnd      (rnd),
    .key_prev (rk_prev),
    .key_next (key_gen)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; start is only honoured outside EXPAND.
  always_comb begin
    state_d   = state_q;
    start_acc = 1'b0;
    last_rnd  = 1'b0;
    case (state_q)
      IDLE, READY: begin
        if (start) begin
          start_acc = 1'b1;
          state_d   = EXPAND;
        end
      end
      EXPAND: begin
        if (rnd == LAST_RND) begin
          last_rnd = 1'b1;
          state_d  = READY;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Round counter and schedule status; rnd rests at 0 outside EXPAND.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rnd        <= 4'd0;
      keys_valid <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start_acc) begin
        rnd        <= 4'd1;
        keys_valid <= 1'b0;
      end else if (last_rnd) begin
        rnd        <= 4'd0;
        keys_valid <= 1'b1;
        done       <= 1'b1;
      end else if (state_q == EXPAND) begin
        rnd <= rnd + 4'd1;
      end
    end
  end

  // Round-key storage: rk[0] loads on start, rk[rnd] fills during EXPAND.
  always_ff @(posedge clk) begin
    if (start_acc)                rk[0]   <= key_in;
    else if (state_q == EXPAND)   rk[rnd] <= key_gen;
  end

  // Registered read port; rejected reads return zero with rd_err.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld <= 1'b0;
      rd_err <= 1'b0;
      rd_key <= '0;
    end else begin
      rd_vld <= rd_en;
      rd_err <= rd_en && !rd_ok;
      if (rd_en) rd_key <= rd_ok ? rk[rd_idx] : '0;
    end
  end

endmodule

// File: tb/tb_key_expand_ctrl.sv
// Directed self-checking bench for key_expand_ctrl.
module tb_key_expand_ctrl;

  localparam logic [127:0] K1      = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K1_R1   = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] K1_R10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] KZ      = 128'h0;
  localparam logic [127:0] KZ_R1   = 128'h62636363626363636263636362636363;
  localparam logic [127:0] KZ_R10  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [127:0] key_in;
  logic         busy;
  logic         done;
  logic         keys_valid;
  logic         rd_en;
  logic [3:0]   rd_idx;
  logic [127:0] rd_key;
  logic         rd_vld;
  logic         rd_err;

  int checks   = 0;
  int failures = 0;
  int n;

  key_expand_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .key_in     (key_in),
    .busy       (busy),
    .done       (done),
    .keys_valid (keys_valid),
    .rd_en      (rd_en),
    .rd_idx     (rd_idx),
    .rd_key     (rd_key),
    .rd_vld     (rd_vld),
    .rd_err     (rd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one rising edge, then settle 1 time unit.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait for done, counting edges; 21 means it never came.
  task automatic wait_done(output int cnt);
    cnt = 0;
    do begin
      step();
      cnt++;
    end while (!done && cnt < 21);
  endtask

  task automatic rd(input logic [3:0] idx);
    rd_en  = 1'b1;
    rd_idx = idx;
    step();
    rd_en  = 1'b0;
  endtask

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    key_in = '0;
    rd_en  = 1'b0;
    rd_idx = '0;
    #2;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_kv", keys_valid, 1'b0);
    chk("rst_rdvld", rd_vld, 1'b0);
    chk("rst_rderr", rd_err, 1'b0);
    chk("rst_rdkey", rd_key, '0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // Expansion of K1 with a second start injected mid-expansion.
    start  = 1'b1;
    key_in = K1;
    step();
    start  = 1'b0;
    chk("a_busy", busy, 1'b1);
    chk("a_kv0", keys_valid, 1'b0);
    n = 0;
    do begin
      if (n == 3) begin
        start  = 1'b1;
        key_in = KZ;
      end else begin
        start = 1'b0;
      end
      step();
      n++;
    end while (!done && n < 21);
    start = 1'b0;
    chk("a_latency", 128'(n), 128'd10);
    chk("a_kv1", keys_valid, 1'b1);
    chk("a_busy_end", busy, 1'b0);
    step();
    chk("a_done_width", done, 1'b0);
    rd(4'd1);
    chk("a_rd1_vld", rd_vld, 1'b1);
    chk("a_rd1_err", rd_err, 1'b0);
    chk("a_rd1", rd_key, K1_R1);
    rd(4'd10);
    chk("a_rd10", rd_key, K1_R10);
    rd(4'd0);
    chk("a_rd0", rd_key, K1);

    // Idle cycle holds rd_key and clears the strobes.
    step();
    chk("hold_vld", rd_vld, 1'b0);
    chk("hold_err", rd_err, 1'b0);
    chk("hold_key", rd_key, K1);

    // Out-of-range indices.
    rd(4'd11);
    chk("idx11_vld", rd_vld, 1'b1);
    chk("idx11_err", rd_err, 1'b1);
    chk("idx11_key", rd_key, '0);
    rd(4'd15);
    chk("idx15_err", rd_err, 1'b1);
    chk("idx15_key", rd_key, '0);

    // Restart from READY with a same-cycle read of idx0.
    start  = 1'b1;
    key_in = KZ;
    rd_en  = 1'b1;
    rd_idx = 4'd0;
    step();
    start  = 1'b0;
    chk("b_old_rk0", rd_key, K1);
    chk("b_old_err", rd_err, 1'b0);
    chk("b_kv_drop", keys_valid, 1'b0);
    chk("b_busy", busy, 1'b1);
    step();
    rd_en  = 1'b0;
    chk("b_exp_vld", rd_vld, 1'b1);
    chk("b_exp_err", rd_err, 1'b1);
    chk("b_exp_key", rd_key, '0);
    wait_done(n);
    chk("b_latency", 128'(n + 1), 128'd10);
    step();
    chk("b_done_width", done, 1'b0);
    rd(4'd1);
    chk("b_rd1", rd_key, KZ_R1);
    rd(4'd10);
    chk("b_rd10", rd_key, KZ_R10);

    // Reset asserted at rnd=5 clears everything immediately.
    start  = 1'b1;
    key_in = K1;
    step();
    start  = 1'b0;
    repeat (4) step();
    chk("c_busy_pre", busy, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("c_busy", busy, 1'b0);
    chk("c_done", done, 1'b0);
    chk("c_kv", keys_valid, 1'b0);
    chk("c_rdvld", rd_vld, 1'b0);
    chk("c_rderr", rd_err, 1'b0);
    chk("c_rdkey", rd_key, '0);
    step();
    rst_n = 1'b1;
    step();
    chk("c_kv_after", keys_valid, 1'b0);
    rd(4'd0);
    chk("c_rd_err", rd_err, 1'b1);
    start  = 1'b1;
    key_in = K1;
    step();
    start  = 1'b0;
    wait_done(n);
    chk("c_latency", 128'(n), 128'd10);
    rd(4'd10);
    chk("c_rd10", rd_key, K1_R10);
    rd(4'd1);
    chk("c_rd1", rd_key, K1_R1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=%0d exp=%0d", 1, 0);
    $fatal(1);
  end

endmodule
